// File: rtl/sdu_dbg_pkg.sv
// sdu_dbg_pkg: op codes, halt causes and run-controller state shared across the debug unit
package sdu_dbg_pkg;
   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_RUN    = 3'd1,
      OP_STEP   = 3'd2,
      OP_HALT   = 3'd3,
      OP_SET_BP = 3'd4,
      OP_CLR_BP = 3'd5
   } op_e;
   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_STEP = 2'd1,
      CAUSE_BP   = 2'd2,
      CAUSE_HOST = 2'd3
   } cause_e;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_REPORT = 2'd3
   } state_e;
endpackage

// File: rtl/sdu_bp_match.sv
// sdu_bp_match: PC breakpoint register file with parallel comparators
module sdu_bp_match #(
   parameter int NBP = 2,
   parameter int PC_W = 32,
   parameter int IW = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set,
   input  logic            clr,
   input  logic [IW-1:0]   idx,
   input  logic [PC_W-1:0] addr,
   input  logic [PC_W-1:0] pc,
   output logic            bp_hit
);
   logic [PC_W-1:0] bp [NBP];
   logic [NBP-1:0] vld;
   always_ff @(posedge clk)
      if (rst) vld <= '0;
      else if (set) begin
         bp[idx] <= addr;
         vld[idx] <= 1'b1;
      end else if (clr) vld[idx] <= 1'b0;
   always_comb begin
      bp_hit = 1'b0;
      for (int i = 0; i < NBP; i++) bp_hit = bp_hit | (vld[i] && bp[i] == pc);
   end
endmodule

// File: rtl/sdu_run_ctrl.sv
// sdu_run_ctrl: freezes, free-runs or steps the CPU via cpu_ce and reports each halt
module sdu_run_ctrl import sdu_dbg_pkg::*; #(
   parameter int NBP = 2,
   parameter int PC_W = 32,
   localparam int IW = NBP > 1 ? $clog2(NBP) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [IW-1:0]   cmd_idx,
   input  logic [PC_W-1:0] cmd_arg,
   input  logic [PC_W-1:0] pc,
   output logic            cpu_ce,
   output logic            halted,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [1:0]      rsp_cause,
   output logic [31:0]     rsp_count
);
   state_e state, state_nx;
   cause_e cause_q, cause_nx;
   logic [PC_W-1:0] step_cnt;
   logic first, bp_hit, acc, stop, last, halt_acc;
   assign acc = cmd_valid & cmd_ready;
   assign halt_acc = acc && cmd_op == OP_HALT;
   // first suppresses the hit so RUN can resume from a breakpointed PC
   assign stop = bp_hit & ~first;
   assign last = step_cnt == PC_W'(1);
   assign rsp_cause = cause_q;
   sdu_bp_match #(.NBP(NBP), .PC_W(PC_W), .IW(IW)) u_bp (
      .clk(clk),
      .rst(rst),
      .set(acc && cmd_op == OP_SET_BP),
      .clr(acc && cmd_op == OP_CLR_BP),
      .idx(cmd_idx),
      .addr(cmd_arg),
      .pc(pc),
      .bp_hit(bp_hit)
   );
   always_ff @(posedge clk)
      if (rst) state <= S_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      cause_nx = CAUSE_NONE;
      case (state)
         S_IDLE: state_nx = acc && cmd_op == OP_RUN ? S_RUN : acc && cmd_op == OP_STEP ? S_STEP : S_IDLE;
         S_RUN: begin
            cause_nx = stop ? CAUSE_BP : CAUSE_HOST;
            state_nx = stop || halt_acc ? S_REPORT : S_RUN;
         end
         S_STEP: begin
            cause_nx = last ? CAUSE_STEP : CAUSE_HOST;
            state_nx = last || halt_acc ? S_REPORT : S_STEP;
         end
         default: state_nx = rsp_ready ? S_IDLE : S_REPORT;
      endcase
   end
   always_comb begin
      cpu_ce = state == S_STEP || (state == S_RUN && !stop);
      cmd_ready = state != S_REPORT;
      rsp_valid = state == S_REPORT;
      halted = state == S_IDLE || state == S_REPORT;
   end
   always_ff @(posedge clk)
      if (rst) begin
         first <= 1'b0;
         step_cnt <= '0;
         rsp_count <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         first <= state == S_IDLE && state_nx == S_RUN;
         if (state == S_IDLE && state_nx != S_IDLE) rsp_count <= '0;
         else if (cpu_ce && !(&rsp_count)) rsp_count <= rsp_count + 32'd1;
         if (state == S_IDLE && state_nx == S_STEP) step_cnt <= cmd_arg == '0 ? PC_W'(1) : cmd_arg;
         else if (state == S_STEP) step_cnt <= step_cnt - PC_W'(1);
         if (state != S_REPORT && state_nx == S_REPORT) cause_q <= cause_nx;
      end
endmodule

// File: tb/tb_sdu_run_ctrl.sv
// tb_sdu_run_ctrl: randomized RUN/STEP/HALT/breakpoint sessions against an instruction-count model
module tb_sdu_run_ctrl;
   import sdu_dbg_pkg::*;
   localparam int NBP = 2;
   logic clk = 0, rst = 1, cmd_valid = 0, rsp_ready = 0, pc_ld = 0;
   logic [2:0] cmd_op = 0;
   logic [0:0] cmd_idx = 0;
   logic [31:0] cmd_arg = 0, pc = 0, pc_val = 0;
   logic cmd_ready, cpu_ce, halted, rsp_valid;
   logic [1:0] rsp_cause;
   logic [31:0] rsp_count;
   int n_chk = 0, n_pass = 0, ce_seen = 0, ce_mark = 0;
   logic [31:0] m_bp [NBP];
   bit m_vld [NBP];

   sdu_run_ctrl #(.NBP(NBP), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_idx(cmd_idx), .cmd_arg(cmd_arg), .pc(pc), .cpu_ce(cpu_ce), .halted(halted),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cause(rsp_cause), .rsp_count(rsp_count)
   );

   always #5 clk = ~clk;
   // CPU stand-in: one 4-byte instruction retired per enabled edge
   always @(posedge clk) pc <= pc_ld ? pc_val : cpu_ce ? pc + 32'd4 : pc;
   always @(negedge clk) if (cpu_ce) ce_seen <= ce_seen + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cmd(input logic [2:0] op, input int idx, input logic [31:0] arg);
      cmd_valid = 1; cmd_op = op; cmd_idx = idx[0:0]; cmd_arg = arg;
      @(posedge clk); @(negedge clk);
      cmd_valid = 0; cmd_op = 0;
   endtask

   task automatic set_pc(input logic [31:0] v);
      pc_ld = 1; pc_val = v;
      @(posedge clk); @(negedge clk);
      pc_ld = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); @(negedge clk);
      rst = 0;
      for (int i = 0; i < NBP; i++) m_vld[i] = 0;
      chk("rst_outs", {cpu_ce, rsp_valid, halted, cmd_ready}, 4'b0011);
      chk("rst_count", rsp_count, 0);
   endtask

   task automatic set_bp(input int idx, input logic [31:0] a);
      cmd(OP_SET_BP, idx, a); m_bp[idx] = a; m_vld[idx] = 1;
   endtask

   task automatic clr_bp(input int idx);
      cmd(OP_CLR_BP, idx, 0); m_vld[idx] = 0;
   endtask

   // instructions retired before RUN from p stops on a breakpoint, -1 if none nearby
   function automatic int stop_dist(input logic [31:0] p);
      for (int n = 1; n <= 64; n++)
         for (int i = 0; i < NBP; i++)
            if (m_vld[i] && m_bp[i] == p + 32'(4 * n)) return n;
      return -1;
   endfunction

   task automatic report(input logic [1:0] ecause, input int ecount, input logic [31:0] pc0, input int elat);
      int w = 0;
      while (!rsp_valid && w < 300) begin @(negedge clk); w++; end
      chk("rsp_valid", rsp_valid, 1);
      if (elat >= 0) chk("rsp_latency", w, elat);
      chk("rsp_cause", rsp_cause, ecause);
      chk("rsp_count", rsp_count, ecount);
      chk("ce_pulses", ce_seen - ce_mark, ecount);
      chk("pc_after", pc, pc0 + 32'(4 * ecount));
      repeat ($urandom_range(0, 4)) begin
         @(negedge clk);
         chk("report_hold", {rsp_valid, cmd_ready, cpu_ce, halted}, 4'b1001);
      end
      rsp_ready = 1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 0;
      chk("back_idle", {rsp_valid, cmd_ready, cpu_ce, halted}, 4'b0101);
      chk("cause_held", rsp_cause, ecause);
   endtask

   // j>0: HALT accepted in the j-th cycle after the RUN is accepted
   task automatic run_case(input logic [31:0] p0, input int j);
      int n = stop_dist(p0);
      set_pc(p0);
      ce_mark = ce_seen;
      cmd(OP_RUN, 0, 0);
      if (j > 0) begin
         repeat (j - 1) @(negedge clk);
         cmd(OP_HALT, 0, 0);
      end
      if (j > 0 && (n < 0 || j <= n)) report(CAUSE_HOST, j, p0, 0);
      else report(CAUSE_BP, n, p0, j > 0 ? 0 : n + 1);
   endtask

   task automatic step_case(input logic [31:0] p0, input int k, input int j);
      int e = k == 0 ? 1 : k;
      set_pc(p0);
      ce_mark = ce_seen;
      cmd(OP_STEP, 0, 32'(k));
      if (j > 0) begin
         repeat (j - 1) @(negedge clk);
         cmd(OP_HALT, 0, 0);
      end
      if (j > 0 && j < e) report(CAUSE_HOST, j, p0, 0);
      else report(CAUSE_STEP, e, p0, j > 0 ? 0 : e);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      do_reset();
      chk("rst_cause", rsp_cause, 0);
      step_case(0, 3, 0);
      step_case(32'h100, 0, 0);
      set_bp(0, 32'h10);
      run_case(0, 0);
      run_case(32'h10, 8);
      clr_bp(0);
      run_case(0, 101);
      set_bp(1, 32'h20);
      run_case(0, 9);
      step_case(0, 2, 2);
      step_case(0, 12, 0);
      for (int it = 0; it < 40; it++) begin
         int n, j, k;
         logic [31:0] p0;
         if ($urandom_range(0, 2) == 0) set_bp($urandom_range(0, NBP - 1), $urandom & 32'h1FC);
         if ($urandom_range(0, 4) == 0) clr_bp($urandom_range(0, NBP - 1));
         p0 = $urandom & 32'h1FC;
         if ($urandom_range(0, 1) == 0) begin
            k = $urandom_range(0, 12);
            j = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, k == 0 ? 1 : k);
            step_case(p0, k, j);
         end else begin
            n = stop_dist(p0);
            if (n < 0) j = $urandom_range(1, 80);
            else j = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, n + 1);
            run_case(p0, j);
         end
      end
      set_bp(0, 32'h40);
      set_pc(0);
      cmd(OP_RUN, 0, 0);
      repeat (3) @(negedge clk);
      do_reset();
      run_case(0, 30);
      set_bp(1, 32'h8);
      set_pc(0);
      cmd(OP_RUN, 0, 0);
      repeat (5) @(negedge clk);
      chk("pre_rst_report", rsp_valid, 1);
      do_reset();
      run_case(0, 10);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
